// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer: one line-aligned bus read per miss, beat assembly, victim pick, single-cycle array write.
// Optional perf counters are enabled by defining ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl #(
  parameter int PLEN                = 32,
  parameter int ICACHE_LINE_WIDTH   = 256,
  parameter int BUS_WIDTH           = 64,
  parameter int ICACHE_SET_ASSOC    = 4,
  parameter int ICACHE_INDEX_WIDTH  = 6,
  parameter int ICACHE_OFFSET_WIDTH = 5,
  parameter int ICACHE_TAG_WIDTH    = PLEN - ICACHE_INDEX_WIDTH - ICACHE_OFFSET_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          miss_valid_i,
  output logic                          miss_ready_o,
  input  logic [PLEN-1:0]               miss_paddr_i,
  input  logic [ICACHE_SET_ASSOC-1:0]   miss_way_valid_i,
  input  logic                          flush_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [PLEN-1:0]               mem_req_addr_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [BUS_WIDTH-1:0]          mem_rsp_data_i,
  input  logic                          mem_rsp_last_i,
  output logic                          refill_we_o,
  output logic [ICACHE_SET_ASSOC-1:0]   refill_way_o,
  output logic [ICACHE_INDEX_WIDTH-1:0] refill_index_o,
  output logic [ICACHE_TAG_WIDTH-1:0]   refill_tag_o,
  output logic [ICACHE_LINE_WIDTH-1:0]  refill_data_o,
  output logic                          refill_done_o,
  output logic                          busy_o
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]                   perf_refill_cnt_o,
  output logic [31:0]                   perf_stall_cycles_o
`endif
);

  localparam int BEATS = ICACHE_LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (ICACHE_SET_ASSOC > 1) ? $clog2(ICACHE_SET_ASSOC) : 1;
  localparam int OFF   = ICACHE_OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic [PTR_W-1:0]               ptr_q;
  logic                           flush_pend_q, from_ptr_q;
  logic [PLEN-1:0]                addr_q;
  logic [ICACHE_SET_ASSOC-1:0]    way_q, victim;
  logic                           victim_from_ptr;
  logic [ICACHE_INDEX_WIDTH-1:0]  idx_q;
  logic [ICACHE_TAG_WIDTH-1:0]    tag_q;
  logic [ICACHE_LINE_WIDTH-1:0]   line_q;
  logic                           last_beat;

  // Beat count alone sequences the line; the bus last marker and offset bits are informational.
  logic unused_bits;
  assign unused_bits = ^{mem_rsp_last_i, miss_paddr_i[OFF-1:0]};

  assign last_beat      = mem_rsp_valid_i && (cnt_q == CNT_W'(BEATS - 1));
  assign mem_req_addr_o = addr_q;
  assign refill_way_o   = way_q;
  assign refill_index_o = idx_q;
  assign refill_tag_o   = tag_q;
  assign refill_data_o  = line_q;

  // First invalid way wins; a full set falls back to the round-robin pointer.
  always_comb begin
    victim          = '0;
    victim_from_ptr = 1'b1;
    for (int w = 0; w < ICACHE_SET_ASSOC; w++) begin
      if (!miss_way_valid_i[w] && victim_from_ptr) begin
        victim[w]       = 1'b1;
        victim_from_ptr = 1'b0;
      end
    end
    if (victim_from_ptr) victim = ICACHE_SET_ASSOC'(1) << ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    refill_we_o     = 1'b0;
    refill_done_o   = 1'b0;
    busy_o          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) state_d = REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = RECV;
      end
      RECV: if (last_beat) state_d = WRITE;
      WRITE: begin
        refill_done_o = 1'b1;
        refill_we_o   = !(flush_pend_q || flush_i);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      ptr_q        <= '0;
      flush_pend_q <= 1'b0;
      from_ptr_q   <= 1'b0;
      addr_q       <= '0;
      way_q        <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      line_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (miss_valid_i) begin
          addr_q       <= {miss_paddr_i[PLEN-1:OFF], {OFF{1'b0}}};
          idx_q        <= miss_paddr_i[OFF +: ICACHE_INDEX_WIDTH];
          tag_q        <= miss_paddr_i[PLEN-1 -: ICACHE_TAG_WIDTH];
          way_q        <= victim;
          from_ptr_q   <= victim_from_ptr;
          flush_pend_q <= 1'b0;
        end
        REQ: begin
          if (flush_i)         flush_pend_q <= 1'b1;
          if (mem_req_ready_i) cnt_q <= '0;
        end
        RECV: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (mem_rsp_valid_i) begin
            for (int b = 0; b < BEATS; b++)
              if (cnt_q == CNT_W'(b)) line_q[b*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          flush_pend_q <= 1'b0;
          // Pointer only advances when it actually chose a way that got written.
          if (refill_we_o && from_ptr_q)
            ptr_q <= (ptr_q == PTR_W'(ICACHE_SET_ASSOC - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_refill_cnt_o   <= '0;
      perf_stall_cycles_o <= '0;
    end else begin
      if (refill_we_o) perf_refill_cnt_o   <= perf_refill_cnt_o + 32'd1;
      if (busy_o)      perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes expected refills/addresses, a negedge monitor pops and compares.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0, rst = 1'b1;
  logic         miss_valid = 1'b0, miss_ready;
  logic [31:0]  miss_paddr = '0;
  logic [3:0]   miss_way_valid = '0;
  logic         flush = 1'b0;
  logic         mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0, mem_rsp_last = 1'b0;
  logic [63:0]  mem_rsp_data = '0;
  logic         refill_we, refill_done, busy;
  logic [3:0]   refill_way;
  logic [5:0]   refill_index;
  logic [20:0]  refill_tag;
  logic [255:0] refill_data;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]  perf_refill_cnt, perf_stall_cycles;
`endif

  icache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
    .miss_paddr_i(miss_paddr), .miss_way_valid_i(miss_way_valid),
    .flush_i(flush),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data), .mem_rsp_last_i(mem_rsp_last),
    .refill_we_o(refill_we), .refill_way_o(refill_way), .refill_index_o(refill_index),
    .refill_tag_o(refill_tag), .refill_data_o(refill_data),
    .refill_done_o(refill_done), .busy_o(busy)
`ifdef ICACHE_REFILL_PERF_EN
    , .perf_refill_cnt_o(perf_refill_cnt), .perf_stall_cycles_o(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           we;
    logic [3:0]   way;
    logic [5:0]   idx;
    logic [20:0]  tag;
    logic [255:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          ptr_m = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // gap >= 0: fixed idle cycles before each beat, gap < 0: random 0..2.
  // fb 0..3: flush alongside that beat, fb == 4: flush on the request handshake, else no flush.
  // rst_at >= 0: assert reset instead of delivering that beat.
  task automatic do_miss(input logic [31:0] pa, input logic [3:0] wv, input logic [255:0] line,
                         input int req_wait, input int gap, input int fb, input int rst_at);
    exp_t e;
    bit   use_ptr;
    int   n;
    e.way   = '0;
    use_ptr = 1'b1;
    for (int w = 0; w < 4; w++)
      if (!wv[w] && use_ptr) begin e.way[w] = 1'b1; use_ptr = 1'b0; end
    if (use_ptr) e.way = 4'(1 << ptr_m);
    e.we   = !(fb >= 0 && fb <= 4);
    e.idx  = pa[10:5];
    e.tag  = pa[31:11];
    e.data = line;
    if (rst_at < 0) begin
      exp_q.push_back(e);
      if (e.we && use_ptr) ptr_m = (ptr_m + 1) % 4;
    end
    addr_q.push_back({pa[31:5], 5'b0});

    n = 0;
    while (!miss_ready && n < 50) begin cyc(); n++; end
    if (!miss_ready) fail("miss_ready_timeout");
    miss_valid = 1'b1; miss_paddr = pa; miss_way_valid = wv;
    cyc();
    miss_valid = 1'b0; miss_paddr = $urandom; miss_way_valid = 4'($urandom);
    for (int i = 0; i < req_wait; i++) cyc();
    mem_req_ready = 1'b1; flush = (fb == 4);
    cyc();
    mem_req_ready = 1'b0; flush = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == rst_at) begin
        rst = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_miss_ready", miss_ready, 1);
        chk("reset_no_we", refill_we, 0);
        chk("reset_no_done", refill_done, 0);
        cyc();
        rst = 1'b0;
        ptr_m = 0;
        return;
      end
      n = (gap >= 0) ? gap : int'($urandom_range(0, 2));
      for (int g = 0; g < n; g++) cyc();
      mem_rsp_valid = 1'b1; mem_rsp_data = line[b*64 +: 64]; mem_rsp_last = (b == 3); flush = (b == fb);
      cyc();
      mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; flush = 1'b0; mem_rsp_data = {$urandom, $urandom};
    end
    chk("done_after_last_beat", refill_done, 1);
    cyc();
  endtask

  // Monitor: every cycle outside reset, compare against the scoreboard queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("miss_ready_vs_busy", miss_ready, !busy);
        if (refill_we && !refill_done) fail("we_without_done");
        if (mem_req_valid) begin
          if (addr_q.size() == 0) fail("unexpected_req");
          else begin
            chk("req_addr", mem_req_addr, addr_q[0]);
            if (mem_req_ready) void'(addr_q.pop_front());
          end
        end
        if (refill_done) begin
          if (exp_q.size() == 0) fail("unexpected_done");
          else begin
            e = exp_q.pop_front();
            chk("refill_we", refill_we, e.we);
            if (e.we) begin
              chk("refill_way", refill_way, e.way);
              chk("refill_index", refill_index, e.idx);
              chk("refill_tag", refill_tag, e.tag);
              chk("refill_data", refill_data, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    logic [255:0] line;
    logic [3:0]   wv;
    int           fb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_we", refill_we, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_way", refill_way, 0);
    chk("rst_data", refill_data, 0);
    rst = 1'b0;
    cyc();

    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_miss(32'h8000_1234, 4'b0000, line, 0, 0, -1, -1);
    do_miss(32'h1000_0040, 4'b1011, line, 0, 0, -1, -1);
    for (int i = 0; i < 5; i++) do_miss(32'h2000_0000 + 32'(i * 32), 4'b1111, line, 0, 0, -1, -1);
    // Backpressure on the request plus idle gaps between beats.
    do_miss(32'h3456_789a, 4'b0111, ~line, 5, 2, -1, -1);
    // Flushed refill must leave the pointer alone; the next full-set miss reuses it.
    do_miss(32'h4000_0100, 4'b1111, line, 1, 0, 1, -1);
    do_miss(32'h4000_0200, 4'b1111, line, 0, 0, -1, -1);
    do_miss(32'h5000_0300, 4'b1111, line, 0, 1, -1, 2);
    do_miss(32'h6000_0400, 4'b1111, ~line, 0, 0, -1, -1);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++) line[k*32 +: 32] = $urandom;
      wv = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
      fb = int'($urandom_range(0, 11));
      if (fb > 4) fb = -1;
      do_miss($urandom, wv, line, int'($urandom_range(0, 3)), -1, fb, -1);
      if ($urandom_range(0, 3) == 0) cyc();
    end

    repeat (3) cyc();
    chk("exp_queue_drained", 256'(exp_q.size()), 0);
    chk("addr_queue_drained", 256'(addr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
